// File: rtl/regfile_debug_dump.sv
// Sweeps a register-file debug read port over [first_addr..last_addr] (wrapping)
// and streams {addr,data} words over valid/ready. Optional macro: REGFILE_DUMP_CHECKSUM_EN.
module regfile_debug_dump #(
  parameter int READ_LATENCY = 1,
  parameter int NUM_REGS     = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [4:0]  first_addr,
  input  logic [4:0]  last_addr,
  output logic [4:0]  dbg_read_address,
  input  logic [31:0] dbg_data_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_addr,
  output logic [31:0] out_data,
`ifdef REGFILE_DUMP_CHECKSUM_EN
  output logic        out_is_checksum,
`endif
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PRESENT, FINISH, CHECKSUM} state_t;

  localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 1);
  localparam logic [4:0] TOP_ADDR  = 5'(NUM_REGS - 1);

  state_t      state_q, state_d;
  logic [4:0]  cur_q, cur_d, last_q, last_d, raddr_q, raddr_d, oaddr_q, oaddr_d;
  logic [31:0] odata_q, odata_d, csum_q, csum_d;
  logic [1:0]  wcnt_q, wcnt_d;
  logic        ovalid_q, ovalid_d;
  logic [4:0]  cur_nxt;

  // Address for the following word; wraps at the top of the register file.
  assign cur_nxt = (cur_q == TOP_ADDR) ? 5'd0 : cur_q + 5'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      last_q   <= '0;
      raddr_q  <= '0;
      oaddr_q  <= '0;
      odata_q  <= '0;
      csum_q   <= '0;
      wcnt_q   <= '0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      last_q   <= last_d;
      raddr_q  <= raddr_d;
      oaddr_q  <= oaddr_d;
      odata_q  <= odata_d;
      csum_q   <= csum_d;
      wcnt_q   <= wcnt_d;
      ovalid_q <= ovalid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    last_d   = last_q;
    raddr_d  = raddr_q;
    oaddr_d  = oaddr_q;
    odata_d  = odata_q;
    csum_d   = csum_q;
    wcnt_d   = wcnt_q;
    ovalid_d = ovalid_q;
    case (state_q)
      IDLE: if (start) begin
        cur_d   = first_addr;
        last_d  = last_addr;
        raddr_d = first_addr;
        csum_d  = '0;
        state_d = ISSUE;
      end
      ISSUE: begin
        raddr_d = cur_q;
        wcnt_d  = WAIT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (wcnt_q == 2'd0) begin
          odata_d  = dbg_data_in;
          oaddr_d  = cur_q;
          ovalid_d = 1'b1;
          state_d  = PRESENT;
        end else begin
          wcnt_d = wcnt_q - 2'd1;
        end
      end
      PRESENT: if (ovalid_q && out_ready) begin
        ovalid_d = 1'b0;
        csum_d   = csum_q ^ odata_q;
        if (cur_q == last_q) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
          // Trailer word carries the XOR of everything delivered, including this word.
          ovalid_d = 1'b1;
          oaddr_d  = 5'd0;
          odata_d  = csum_q ^ odata_q;
          state_d  = CHECKSUM;
`else
          state_d  = FINISH;
`endif
        end else begin
          cur_d   = cur_nxt;
          raddr_d = cur_nxt;
          state_d = ISSUE;
        end
      end
      CHECKSUM: if (ovalid_q && out_ready) begin
        ovalid_d = 1'b0;
        state_d  = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort wins over a same-cycle transfer; the pending word is dropped.
    if (abort && state_q != IDLE) begin
      state_d  = IDLE;
      ovalid_d = 1'b0;
    end
  end

  assign dbg_read_address = raddr_q;
  assign out_valid        = ovalid_q;
  assign out_addr         = oaddr_q;
  assign out_data         = odata_q;
  assign busy             = (state_q != IDLE);
  assign done             = (state_q == FINISH);
`ifdef REGFILE_DUMP_CHECKSUM_EN
  assign out_is_checksum  = (state_q == CHECKSUM);
`endif

endmodule

// File: tb/tb_regfile_debug_dump.sv
// Directed bench for regfile_debug_dump against a latency-1 register file model
// holding reset values r[i]=i.
module tb_regfile_debug_dump;
  logic        clock = 1'b0;
  logic        reset, start, abort, out_ready, out_valid, busy, done;
  logic [4:0]  first_addr, last_addr, dbg_read_address, out_addr;
  logic [31:0] dbg_data_in, out_data;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic        out_is_checksum;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] regs [32];
  logic [4:0]  wa [$];
  logic [31:0] wd [$];
  logic        wc [$];
  int first_v, ndone, done_cyc, idle_cyc;

  regfile_debug_dump #(.READ_LATENCY(1), .NUM_REGS(32)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .first_addr(first_addr), .last_addr(last_addr),
    .dbg_read_address(dbg_read_address), .dbg_data_in(dbg_data_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data),
`ifdef REGFILE_DUMP_CHECKSUM_EN
    .out_is_checksum(out_is_checksum),
`endif
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) dbg_data_in <= regs[dbg_read_address];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Logs every presented word (c = samples after the start edge) until idle.
  task automatic collect(input int c0);
    wa.delete(); wd.delete(); wc.delete();
    first_v = -1; ndone = 0; done_cyc = -1; idle_cyc = -1;
    for (int c = c0; c <= c0 + 400; c++) begin
      if (!busy) begin idle_cyc = c; break; end
      if (out_valid) begin
        if (first_v < 0) first_v = c;
        wa.push_back(out_addr);
        wd.push_back(out_data);
`ifdef REGFILE_DUMP_CHECKSUM_EN
        wc.push_back(out_is_checksum);
`else
        wc.push_back(1'b0);
`endif
      end
      if (done) begin ndone++; done_cyc = c; end
      tick();
    end
  endtask

  task automatic dump(input logic [4:0] f, input logic [4:0] l);
    first_addr = f; last_addr = l; start = 1'b1;
    tick();
    start = 1'b0;
    collect(0);
  endtask

  initial begin
    int stable;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i);
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    first_addr = '0; last_addr = '0;
    tick(); tick();
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_busy",  {31'd0, busy}, 0);
    chk("rst_done",  {31'd0, done}, 0);
    chk("rst_raddr", {27'd0, dbg_read_address}, 0);
    chk("rst_oaddr", {27'd0, out_addr}, 0);
    chk("rst_odata", out_data, 0);
    reset = 1'b0;
    tick();

    // 0..3 with ready high: word every 3 cycles, first presented 2 samples after start edge
    dump(5'd0, 5'd3);
    chk("t1_first_valid", 32'(first_v), 2);
    chk("t1_words", 32'(wa.size()), 4);
    for (int k = 0; k < 4 && k < wa.size(); k++) begin
      chk($sformatf("t1_addr%0d", k), {27'd0, wa[k]}, 32'(k));
      chk($sformatf("t1_data%0d", k), wd[k], 32'(k));
    end
    chk("t1_ndone", 32'(ndone), 1);
    chk("t1_done_cyc", 32'(done_cyc), 12);
    chk("t1_idle_cyc", 32'(idle_cyc), 13);

    // wrap 30,31,0,1
    dump(5'd30, 5'd1);
    chk("t2_words", 32'(wa.size()), 4);
    if (wa.size() == 4) begin
      chk("t2_a0", {27'd0, wa[0]}, 30); chk("t2_d0", wd[0], 30);
      chk("t2_a1", {27'd0, wa[1]}, 31); chk("t2_d1", wd[1], 31);
      chk("t2_a2", {27'd0, wa[2]}, 0);  chk("t2_d2", wd[2], 0);
      chk("t2_a3", {27'd0, wa[3]}, 1);  chk("t2_d3", wd[3], 1);
    end

    // full sweep: first = last+1
    dump(5'd8, 5'd7);
    chk("t2b_words", 32'(wa.size()), 32);
    if (wa.size() == 32) chk("t2b_last_addr", {27'd0, wa[31]}, 7);

    // single word with backpressure
    out_ready = 1'b0;
    first_addr = 5'd5; last_addr = 5'd5; start = 1'b1;
    tick(); start = 1'b0; tick(); tick();
    stable = 1;
    for (int c = 0; c < 10; c++) begin
      if (!(out_valid === 1'b1 && out_addr === 5'd5 && out_data === 32'd5)) stable = 0;
      tick();
    end
    chk("t3_stable", 32'(stable), 1);
    out_ready = 1'b1;
    collect(0);
    chk("t3_words", 32'(wa.size()), 1);
    chk("t3_ndone", 32'(ndone), 1);

    // abort while second word of 0..7 is presented
    first_addr = 5'd0; last_addr = 5'd7; start = 1'b1;
    tick(); start = 1'b0;
    stable = 0;
    for (int c = 0; c < 50 && stable < 2; c++) begin
      if (out_valid) stable++;
      if (stable < 2) tick();
    end
    chk("t4_at_word1", {27'd0, out_addr}, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t4_valid", {31'd0, out_valid}, 0);
    chk("t4_busy",  {31'd0, busy}, 0);
    stable = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) stable++;
      tick();
    end
    chk("t4_no_done", 32'(stable), 0);
    dump(5'd0, 5'd3);
    chk("t4_redump_words", 32'(wa.size()), 4);
    if (wa.size() > 0) chk("t4_redump_a0", {27'd0, wa[0]}, 0);

    // extra start while busy is ignored
    first_addr = 5'd0; last_addr = 5'd7; start = 1'b1;
    tick(); start = 1'b0;
    first_addr = 5'd20; last_addr = 5'd21; start = 1'b1;
    tick(); start = 1'b0;
    collect(2);
    chk("t5_words", 32'(wa.size()), 8);
    if (wa.size() == 8) begin
      chk("t5_a0", {27'd0, wa[0]}, 0);
      chk("t5_a7", {27'd0, wa[7]}, 7);
    end

    // reset mid-dump
    first_addr = 5'd9; last_addr = 5'd12; start = 1'b1;
    tick(); start = 1'b0; tick(); tick();
    chk("t5_pre_addr", {27'd0, out_addr}, 9);
    reset = 1'b1; tick();
    chk("t5_rst_valid", {31'd0, out_valid}, 0);
    chk("t5_rst_busy",  {31'd0, busy}, 0);
    chk("t5_rst_oaddr", {27'd0, out_addr}, 0);
    chk("t5_rst_odata", out_data, 0);
    chk("t5_rst_raddr", {27'd0, dbg_read_address}, 0);
    reset = 1'b0; tick();

`ifdef REGFILE_DUMP_CHECKSUM_EN
    dump(5'd1, 5'd3);
    chk("ck_words", 32'(wa.size()), 4);
    if (wa.size() == 4) begin
      chk("ck_d2", wd[2], 3);
      chk("ck_flag_data", {31'd0, wc[2]}, 0);
      chk("ck_addr", {27'd0, wa[3]}, 0);
      chk("ck_sum", wd[3], 32'h0);
      chk("ck_flag", {31'd0, wc[3]}, 1);
    end
    chk("ck_ndone", 32'(ndone), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
